// File: rtl/routing_pkg.sv
// ---------------------------------------------------------------------------
// routing_pkg
// Shared definitions for the routing-table init loader: entry geometry,
// header field widths, table index widths, loader FSM states and the error
// codes reported to the system top.
// ---------------------------------------------------------------------------
package routing_pkg;

   localparam int ENTRY_WIDTH     = 192;
   localparam int WORDS_PER_ENTRY = 6;
   localparam int WORD_WIDTH      = 32;

   // Only the low bits of each header word carry the count
   localparam int HOST_CNT_W = 7;
   localparam int SW_CNT_W   = 5;

   localparam int HOST_IDX_W = 6;
   localparam int PATH_IDX_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HOST_HDR,
      ST_HOST_BODY,
      ST_PATH_HDR,
      ST_PATH_BODY,
      ST_DONE,
      ST_ERR
   } loader_state_e;

   localparam logic [1:0] ERR_NONE         = 2'b00;
   localparam logic [1:0] ERR_HOST_COUNT   = 2'b01;
   localparam logic [1:0] ERR_SWITCH_COUNT = 2'b10;

endpackage

// File: rtl/entry_word_assembler.sv
// ---------------------------------------------------------------------------
// entry_word_assembler
// Collects WORDS consecutive ROM words into one wide table entry. The first
// word lands in the least significant slice. The last word is not stored:
// it is passed straight through into the top slice of o_entry so the
// complete entry is available on the same edge that samples it.
//
// Ports
//   clk, rst_n : clock, async active-low reset
//   i_clear    : restart collection at word 0
//   i_valid    : i_word is a body word to be consumed on this edge
//   i_word     : current ROM word
//   o_done     : high while i_word is the final word of an entry
//   o_entry    : assembled entry (valid while o_done is high)
// ---------------------------------------------------------------------------
module entry_word_assembler
   import routing_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int WORDS      = WORDS_PER_ENTRY
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_clear,
   input  logic                        i_valid,
   input  logic [DATA_WIDTH-1:0]       i_word,
   output logic                        o_done,
   output logic [DATA_WIDTH*WORDS-1:0] o_entry
);

   localparam logic [2:0] LAST_IDX = 3'(WORDS - 1);

   logic [2:0]                        r_wordIdx;
   logic [DATA_WIDTH*(WORDS-1)-1:0]   r_words;

   // Store words 0..WORDS-2 into their slice and step the word index,
   // wrapping after the last word so back-to-back entries need no gap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wordIdx <= '0;
         r_words   <= '0;
      end else if (i_clear) begin
         r_wordIdx <= '0;
      end else if (i_valid) begin
         for (int k = 0; k < WORDS - 1; k++) begin
            if (r_wordIdx == 3'(k)) begin
               r_words[k*DATA_WIDTH +: DATA_WIDTH] <= i_word;
            end
         end
         r_wordIdx <= (r_wordIdx == LAST_IDX) ? 3'd0 : r_wordIdx + 3'd1;
      end
   end

   assign o_done  = i_valid && (r_wordIdx == LAST_IDX);
   assign o_entry = {i_word, r_words};

endmodule

// File: rtl/routing_table_loader.sv
// ---------------------------------------------------------------------------
// routing_table_loader
// Streams the routing image (host table then path table) out of a
// combinational word-read ROM and writes each 192-bit entry into the host
// and path table RAM write ports. One ROM word is consumed per cycle.
//
// Ports
//   clk, rst_n            : clock, async active-low reset
//   start_init            : single-cycle start pulse (ignored while busy)
//   mem_addr / mem_data   : registered ROM byte address / word at that address
//   init_busy             : load in progress
//   system_ready          : level, set after a successful load
//   init_error/error_code : level + reason, set after an aborted load
//   host_count            : parsed host count
//   switch_count          : parsed switch count
//   host_wr_*             : host table write port (one-cycle strobe)
//   path_wr_*             : path table write port, addr = {src, dst}
// ---------------------------------------------------------------------------
module routing_table_loader #(
   parameter int                    MAX_HOSTS    = 64,
   parameter int                    MAX_SWITCHES = 16,
   parameter int                    ADDR_WIDTH   = 32,
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    ENTRY_WIDTH  = 192,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start_init,
   output logic [ADDR_WIDTH-1:0]  mem_addr,
   input  logic [DATA_WIDTH-1:0]  mem_data,
   output logic                   init_busy,
   output logic                   system_ready,
   output logic                   init_error,
   output logic [1:0]             error_code,
   output logic [6:0]             host_count,
   output logic [4:0]             switch_count,
   output logic                   host_wr_en,
   output logic [5:0]             host_wr_addr,
   output logic [ENTRY_WIDTH-1:0] host_wr_data,
   output logic                   path_wr_en,
   output logic [7:0]             path_wr_addr,
   output logic [ENTRY_WIDTH-1:0] path_wr_data
);

   import routing_pkg::*;

   localparam logic [6:0]            HOST_LIMIT = 7'(MAX_HOSTS);
   localparam logic [4:0]            SW_LIMIT   = 5'(MAX_SWITCHES);
   localparam logic [ADDR_WIDTH-1:0] WORD_STEP  = ADDR_WIDTH'(4);

   loader_state_e            r_state;
   logic [5:0]               r_hostIdx;
   logic [3:0]               r_src;
   logic [3:0]               r_dst;

   logic                     w_startAccept;
   logic                     w_bodyWord;
   logic                     w_entryDone;
   logic [ENTRY_WIDTH-1:0]   w_entry;
   logic [6:0]               w_hdrHosts;
   logic [4:0]               w_hdrSwitches;
   logic                     w_hostLast;
   logic                     w_dstLast;
   logic                     w_srcLast;

   assign w_startAccept = start_init &&
                          (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERR);
   assign w_bodyWord    = (r_state == ST_HOST_BODY) || (r_state == ST_PATH_BODY);
   assign w_hdrHosts    = mem_data[6:0];
   assign w_hdrSwitches = mem_data[4:0];

   // Counts are nonzero whenever a body state is active, so the -1 never wraps
   assign w_hostLast = ({1'b0, r_hostIdx} == host_count - 7'd1);
   assign w_dstLast  = ({1'b0, r_dst} == switch_count - 5'd1);
   assign w_srcLast  = ({1'b0, r_src} == switch_count - 5'd1);

   entry_word_assembler #(
      .DATA_WIDTH (DATA_WIDTH),
      .WORDS      (WORDS_PER_ENTRY)
   ) u_assembler (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (w_startAccept),
      .i_valid (w_bodyWord),
      .i_word  (mem_data),
      .o_done  (w_entryDone),
      .o_entry (w_entry)
   );

   // Loader FSM. Every fetch state consumes the word at mem_addr and steps
   // mem_addr on the same edge; write strobes default low so each completed
   // entry produces exactly one strobe cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_hostIdx    <= '0;
         r_src        <= '0;
         r_dst        <= '0;
         mem_addr     <= '0;
         init_busy    <= 1'b0;
         system_ready <= 1'b0;
         init_error   <= 1'b0;
         error_code   <= ERR_NONE;
         host_count   <= '0;
         switch_count <= '0;
         host_wr_en   <= 1'b0;
         host_wr_addr <= '0;
         host_wr_data <= '0;
         path_wr_en   <= 1'b0;
         path_wr_addr <= '0;
         path_wr_data <= '0;
      end else begin
         host_wr_en <= 1'b0;
         path_wr_en <= 1'b0;
         case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (start_init) begin
                  r_state      <= ST_HOST_HDR;
                  mem_addr     <= BASE_ADDR;
                  init_busy    <= 1'b1;
                  system_ready <= 1'b0;
                  init_error   <= 1'b0;
                  error_code   <= ERR_NONE;
               end
            end
            ST_HOST_HDR: begin
               mem_addr   <= mem_addr + WORD_STEP;
               host_count <= w_hdrHosts;
               r_hostIdx  <= '0;
               if (w_hdrHosts > HOST_LIMIT) begin
                  r_state    <= ST_ERR;
                  error_code <= ERR_HOST_COUNT;
                  init_error <= 1'b1;
                  init_busy  <= 1'b0;
               end else if (w_hdrHosts == 7'd0) begin
                  r_state <= ST_PATH_HDR;
               end else begin
                  r_state <= ST_HOST_BODY;
               end
            end
            ST_HOST_BODY: begin
               mem_addr <= mem_addr + WORD_STEP;
               if (w_entryDone) begin
                  host_wr_en   <= 1'b1;
                  host_wr_addr <= r_hostIdx;
                  host_wr_data <= w_entry;
                  r_hostIdx    <= r_hostIdx + 6'd1;
                  if (w_hostLast) begin
                     r_state <= ST_PATH_HDR;
                  end
               end
            end
            ST_PATH_HDR: begin
               mem_addr     <= mem_addr + WORD_STEP;
               switch_count <= w_hdrSwitches;
               r_src        <= '0;
               r_dst        <= '0;
               if (w_hdrSwitches > SW_LIMIT) begin
                  r_state    <= ST_ERR;
                  error_code <= ERR_SWITCH_COUNT;
                  init_error <= 1'b1;
                  init_busy  <= 1'b0;
               end else if (w_hdrSwitches == 5'd0) begin
                  r_state      <= ST_DONE;
                  system_ready <= 1'b1;
                  init_busy    <= 1'b0;
               end else begin
                  r_state <= ST_PATH_BODY;
               end
            end
            ST_PATH_BODY: begin
               mem_addr <= mem_addr + WORD_STEP;
               if (w_entryDone) begin
                  path_wr_en   <= 1'b1;
                  path_wr_addr <= {r_src, r_dst};
                  path_wr_data <= w_entry;
                  if (w_dstLast) begin
                     r_dst <= '0;
                     r_src <= r_src + 4'd1;
                     if (w_srcLast) begin
                        r_state      <= ST_DONE;
                        system_ready <= 1'b1;
                        init_busy    <= 1'b0;
                     end
                  end else begin
                     r_dst <= r_dst + 4'd1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_routing_table_loader.sv
// ---------------------------------------------------------------------------
// tb_routing_table_loader
// Builds random routing images in a behavioural ROM, derives the expected
// table write sequence, latency and final address directly from the image
// layout, and compares them against what the loader produces.
// ---------------------------------------------------------------------------
module tb_routing_table_loader;

   typedef struct packed {
      logic [7:0]   addr;
      logic [191:0] data;
   } wr_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start_init;
   logic [31:0]  mem_addr;
   logic [31:0]  mem_data;
   logic         init_busy;
   logic         system_ready;
   logic         init_error;
   logic [1:0]   error_code;
   logic [6:0]   host_count;
   logic [4:0]   switch_count;
   logic         host_wr_en;
   logic [5:0]   host_wr_addr;
   logic [191:0] host_wr_data;
   logic         path_wr_en;
   logic [7:0]   path_wr_addr;
   logic [191:0] path_wr_data;

   logic [31:0] rom [0:1023];
   wr_t expHost[$];
   wr_t expPath[$];
   wr_t gotHost[$];
   wr_t gotPath[$];

   int cyc      = 0;
   int startCyc = 0;
   int nChecks  = 0;
   int nFails   = 0;

   always #5 clk = ~clk;

   assign mem_data = rom[mem_addr[11:2]];

   routing_table_loader dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_init   (start_init),
      .mem_addr     (mem_addr),
      .mem_data     (mem_data),
      .init_busy    (init_busy),
      .system_ready (system_ready),
      .init_error   (init_error),
      .error_code   (error_code),
      .host_count   (host_count),
      .switch_count (switch_count),
      .host_wr_en   (host_wr_en),
      .host_wr_addr (host_wr_addr),
      .host_wr_data (host_wr_data),
      .path_wr_en   (path_wr_en),
      .path_wr_addr (path_wr_addr),
      .path_wr_data (path_wr_data)
   );

   // Cycle counter used to measure start-to-ready latency
   always @(posedge clk) cyc = cyc + 1;

   // Record every table write strobe mid-cycle
   always @(negedge clk) begin
      if (host_wr_en) gotHost.push_back('{{2'b00, host_wr_addr}, host_wr_data});
      if (path_wr_en) gotPath.push_back('{path_wr_addr, path_wr_data});
   end

   // Fill the ROM with a fresh image and derive the expected write lists
   task automatic buildImage(input int h, input int s);
      int idx;
      logic [191:0] e;
      for (int i = 0; i < 1024; i++) rom[i] = $urandom();
      expHost.delete(); expPath.delete(); gotHost.delete(); gotPath.delete();
      idx = 0;
      rom[idx] = ($urandom() & 32'hFFFF_FF80) | 32'(h);
      idx++;
      if (h <= 64) begin
         for (int i = 0; i < h; i++) begin
            for (int w = 0; w < 6; w++) begin
               rom[idx] = $urandom();
               e[w*32 +: 32] = rom[idx];
               idx++;
            end
            expHost.push_back('{8'(i), e});
         end
         rom[idx] = ($urandom() & 32'hFFFF_FFE0) | 32'(s);
         idx++;
         if (s <= 16) begin
            for (int src = 0; src < s; src++) begin
               for (int dst = 0; dst < s; dst++) begin
                  for (int w = 0; w < 6; w++) begin
                     rom[idx] = $urandom();
                     e[w*32 +: 32] = rom[idx];
                     idx++;
                  end
                  expPath.push_back('{8'(src*16 + dst), e});
               end
            end
         end
      end
   endtask

   task automatic pulseStart();
      @(negedge clk);
      start_init = 1'b1;
      @(negedge clk);
      start_init = 1'b0;
      startCyc = cyc;
   endtask

   // Wait for ready or error, bounded; then let the final strobe drain
   task automatic waitDone(input int maxCyc, output int lat, output bit timedOut);
      timedOut = 1'b1;
      lat = 0;
      for (int i = 0; i < maxCyc; i++) begin
         @(negedge clk);
         if (system_ready || init_error) begin
            timedOut = 1'b0;
            lat = cyc - startCyc;
            break;
         end
      end
      repeat (2) @(negedge clk);
   endtask

   // -2 on length difference, index of first differing write, or -1 if equal
   function automatic int firstDiff(input wr_t e[$], input wr_t g[$]);
      if (e.size() != g.size()) return -2;
      foreach (e[i]) if (e[i] !== g[i]) return i;
      return -1;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      start_init = 1'b0;
      repeat (2) @(negedge clk);
      nChecks++;
      if (mem_addr !== 32'd0) begin nFails++; $display("[TB] FAIL reset_mem_addr got %h want 0", mem_addr); end
      nChecks++;
      if ({init_busy, system_ready, init_error} !== 3'b000) begin
         nFails++; $display("[TB] FAIL reset_status got %b want 000", {init_busy, system_ready, init_error});
      end
      nChecks++;
      if ({error_code, host_count, switch_count} !== 14'd0) begin
         nFails++; $display("[TB] FAIL reset_counts got %h want 0", {error_code, host_count, switch_count});
      end
      nChecks++;
      if ({host_wr_en, path_wr_en} !== 2'b00) begin
         nFails++; $display("[TB] FAIL reset_strobes got %b want 00", {host_wr_en, path_wr_en});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_load(input int h, input int s);
      int lat, expLat, d;
      bit to;
      buildImage(h, s);
      expLat = 2 + 6*h + 6*s*s;
      pulseStart();
      nChecks++;
      if (init_busy !== 1'b1 || mem_addr !== 32'd0) begin
         nFails++; $display("[TB] FAIL load_start_busy h=%0d s=%0d got busy=%b addr=%h want busy=1 addr=0", h, s, init_busy, mem_addr);
      end
      waitDone(2000, lat, to);
      nChecks++;
      if (to !== 1'b0) begin nFails++; $display("[TB] FAIL load_timeout h=%0d s=%0d got timeout want completion", h, s); end
      nChecks++;
      if (lat !== expLat) begin nFails++; $display("[TB] FAIL load_latency h=%0d s=%0d got %0d want %0d", h, s, lat, expLat); end
      nChecks++;
      if ({system_ready, init_error, init_busy} !== 3'b100) begin
         nFails++; $display("[TB] FAIL load_status h=%0d s=%0d got %b want 100", h, s, {system_ready, init_error, init_busy});
      end
      d = firstDiff(expHost, gotHost);
      nChecks++;
      if (d !== -1) begin nFails++; $display("[TB] FAIL load_host_writes h=%0d s=%0d diff=%0d got %0d writes want %0d", h, s, d, gotHost.size(), expHost.size()); end
      d = firstDiff(expPath, gotPath);
      nChecks++;
      if (d !== -1) begin nFails++; $display("[TB] FAIL load_path_writes h=%0d s=%0d diff=%0d got %0d writes want %0d", h, s, d, gotPath.size(), expPath.size()); end
      nChecks++;
      if (mem_addr !== 32'(4*expLat)) begin nFails++; $display("[TB] FAIL load_mem_addr h=%0d s=%0d got %h want %h", h, s, mem_addr, 32'(4*expLat)); end
      nChecks++;
      if (host_count !== 7'(h) || switch_count !== 5'(s)) begin
         nFails++; $display("[TB] FAIL load_counts got %0d/%0d want %0d/%0d", host_count, switch_count, h, s);
      end
   endtask

   task automatic test_random_loads();
      for (int n = 0; n < 4; n++) test_load($urandom_range(0, 5), $urandom_range(0, 4));
   endtask

   task automatic test_host_overflow();
      int lat, h;
      bit to;
      h = 65 + $urandom_range(0, 62);
      buildImage(h, 1);
      pulseStart();
      waitDone(100, lat, to);
      nChecks++;
      if (to !== 1'b0 || lat !== 1) begin nFails++; $display("[TB] FAIL hovf_latency got to=%b lat=%0d want 0/1", to, lat); end
      nChecks++;
      if ({init_error, system_ready, init_busy, error_code} !== 5'b10001) begin
         nFails++; $display("[TB] FAIL hovf_status got %b want 10001", {init_error, system_ready, init_busy, error_code});
      end
      nChecks++;
      if (gotHost.size() !== 0 || gotPath.size() !== 0) begin
         nFails++; $display("[TB] FAIL hovf_writes got %0d/%0d want 0/0", gotHost.size(), gotPath.size());
      end
      nChecks++;
      if (host_count !== 7'(h)) begin nFails++; $display("[TB] FAIL hovf_host_count got %0d want %0d", host_count, h); end
   endtask

   task automatic test_switch_overflow();
      int lat, s, d;
      bit to;
      s = 17 + $urandom_range(0, 14);
      buildImage(1, s);
      pulseStart();
      waitDone(200, lat, to);
      nChecks++;
      if (to !== 1'b0 || lat !== 8) begin nFails++; $display("[TB] FAIL sovf_latency got to=%b lat=%0d want 0/8", to, lat); end
      nChecks++;
      if ({init_error, system_ready, init_busy, error_code} !== 5'b10010) begin
         nFails++; $display("[TB] FAIL sovf_status got %b want 10010", {init_error, system_ready, init_busy, error_code});
      end
      d = firstDiff(expHost, gotHost);
      nChecks++;
      if (d !== -1 || gotPath.size() !== 0) begin
         nFails++; $display("[TB] FAIL sovf_writes diff=%0d host=%0d path=%0d want host=1 path=0", d, gotHost.size(), gotPath.size());
      end
      nChecks++;
      if (switch_count !== 5'(s)) begin nFails++; $display("[TB] FAIL sovf_switch_count got %0d want %0d", switch_count, s); end
   endtask

   task automatic test_back_to_back();
      int lat, d;
      bit to;
      buildImage(3, 2);
      pulseStart();
      repeat (7) @(negedge clk);
      start_init = 1'b1;
      @(negedge clk);
      start_init = 1'b0;
      waitDone(2000, lat, to);
      nChecks++;
      if (to !== 1'b0 || lat !== 44) begin nFails++; $display("[TB] FAIL repulse_latency got to=%b lat=%0d want 0/44", to, lat); end
      d = firstDiff(expHost, gotHost) + 10 * firstDiff(expPath, gotPath);
      nChecks++;
      if (d !== -11) begin nFails++; $display("[TB] FAIL repulse_writes got code %0d want -11", d); end
      gotHost.delete();
      gotPath.delete();
      pulseStart();
      nChecks++;
      if (system_ready !== 1'b0 || init_busy !== 1'b1) begin
         nFails++; $display("[TB] FAIL reload_clear got ready=%b busy=%b want 0/1", system_ready, init_busy);
      end
      waitDone(2000, lat, to);
      nChecks++;
      if (to !== 1'b0 || lat !== 44 || system_ready !== 1'b1) begin
         nFails++; $display("[TB] FAIL reload_latency got to=%b lat=%0d ready=%b want 0/44/1", to, lat, system_ready);
      end
      d = firstDiff(expHost, gotHost) + 10 * firstDiff(expPath, gotPath);
      nChecks++;
      if (d !== -11) begin nFails++; $display("[TB] FAIL reload_writes got code %0d want -11", d); end
   endtask

   task automatic test_reset_midload();
      buildImage(3, 1);
      pulseStart();
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      nChecks++;
      if (init_busy !== 1'b0 || mem_addr !== 32'd0) begin
         nFails++; $display("[TB] FAIL midreset_busy_addr got busy=%b addr=%h want 0/0", init_busy, mem_addr);
      end
      nChecks++;
      if ({system_ready, init_error, host_wr_en, path_wr_en, host_count, switch_count, host_wr_addr} !== 22'd0) begin
         nFails++; $display("[TB] FAIL midreset_outputs got %h want 0",
                            {system_ready, init_error, host_wr_en, path_wr_en, host_count, switch_count, host_wr_addr});
      end
      nChecks++;
      if (host_wr_data !== 192'd0 || path_wr_data !== 192'd0) begin
         nFails++; $display("[TB] FAIL midreset_data got nonzero want 0");
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_load(2, 1);
   endtask

   initial begin
      test_reset();
      test_load(2, 2);
      test_load(0, 0);
      test_random_loads();
      test_host_overflow();
      test_switch_overflow();
      test_back_to_back();
      test_reset_midload();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/routing_table_loader.md
Name: routing_table_loader

Overview:
- Init-time loader directly upstream of the lookup tables inside routing_system_top.
- Streams the routing binary image (host table, then path table) out of a combinational word-read ROM port (mem_addr/mem_data) and assembles 192-bit entries.
- Writes each entry into the host and path table RAM write ports.
- Reports busy/ready/error to the system top, which gates lookups on system_ready.

Parameters:
- MAX_HOSTS, 64, host table depth; host index width is 6.
- MAX_SWITCHES, 16, switch count limit; path table depth is MAX_SWITCHES*MAX_SWITCHES.
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, ROM word width (fixed at 32).
- ENTRY_WIDTH, 192, host/path entry width (6 words).
- BASE_ADDR, 0, byte address of the image start.

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- start_init  in  1  single-cycle start pulse
- mem_addr  out  ADDR_WIDTH  ROM byte address, registered, always word aligned
- mem_data  in  DATA_WIDTH  ROM word at mem_addr, little-endian, valid in the same cycle
- init_busy  out  1  load in progress
- system_ready  out  1  level; high after a successful load
- init_error  out  1  level; high after an aborted load
- error_code  out  2  01 = host count too large, 10 = switch count too large
- host_count  out  7  parsed host count
- switch_count  out  5  parsed switch count
- host_wr_en  out  1  host RAM write strobe
- host_wr_addr  out  6  host index
- host_wr_data  out  ENTRY_WIDTH  host entry
- path_wr_en  out  1  path RAM write strobe
- path_wr_addr  out  8  path index = src_sw*MAX_SWITCHES + dst_sw
- path_wr_data  out  ENTRY_WIDTH  path entry

Behaviour:
- Image layout, in words at consecutive addresses from BASE_ADDR:
  - H (host count, low 7 bits used).
  - H host entries, 6 words each.
  - S (switch count, low 5 bits used).
  - S*S path entries, 6 words each, row-major by (src_sw, dst_sw).
- Entry assembly: the first word of an entry lands in bits [31:0], the sixth in [191:160].
- Word fetch: the loader samples mem_data on the rising edge where its registered mem_addr addresses that word, then adds 4 to mem_addr on that same edge. Throughput is one word per cycle, no stalls.
- Reset: the FSM returns to IDLE and every output is 0, including mem_addr. Reset does not restore mem_addr to BASE_ADDR.
- States: IDLE, HOST_HDR, HOST_BODY, PATH_HDR, PATH_BODY, DONE, ERR.
- IDLE / DONE / ERR:
  - start_init moves the FSM to HOST_HDR.
  - mem_addr is set to BASE_ADDR.
  - system_ready and init_error are cleared.
  - init_busy goes high on the following cycle.
- start_init during any busy state is ignored.
- HOST_HDR:
  - Samples H.
  - If H > MAX_HOSTS: go to ERR with error_code 01.
  - Else if H == 0: go to PATH_HDR.
  - Otherwise go to HOST_BODY.
- HOST_BODY:
  - Word counter runs 0..5; entry counter counts hosts.
  - On the edge that samples word 5, register host_wr_data and host_wr_addr = entry index.
  - host_wr_en is high for exactly the next cycle.
  - After entry H-1, go to PATH_HDR.
- PATH_HDR:
  - Samples S.
  - If S > MAX_SWITCHES: go to ERR with error_code 10.
  - Else if S == 0: go to DONE.
  - Otherwise go to PATH_BODY.
- PATH_BODY:
  - Same entry assembly as HOST_BODY.
  - src/dst counters: dst wraps at S-1 and then increments src.
  - path_wr_addr = {src[3:0], dst[3:0]}.
  - After entry (S-1, S-1), go to DONE.
- DONE: system_ready=1, init_busy=0.
- ERR: init_error=1, init_busy=0, system_ready=0. Tables hold partial contents; no further writes occur.
- A final write strobe may coincide with the first DONE cycle.
- Total cycles from the start edge to system_ready high = 2 + 6H + 6S².
- host_count and switch_count update when their header word is sampled and hold until the next start.

Decomposition:
- Shared package routing_pkg holds:
  - ENTRY_WIDTH, WORDS_PER_ENTRY = 6.
  - Header field widths.
  - The loader state enum.
  - Error-code constants.
- One natural sub-module: entry_word_assembler, a 6-word shift/collect register with a done pulse. It is instantiated once and shared by the host and path phases.

Test Plan:
- H=2, S=2:
  - Two host_wr_en pulses at addresses 0 and 1, with data equal to the image words.
  - Four path_wr_en pulses at addresses 0x00, 0x01, 0x10, 0x11.
  - system_ready rises 38 cycles after start.
  - mem_addr ends at 0x98.
- H=0, S=0: no write strobes; system_ready rises 2 cycles after start.
- H=65: ERR, error_code=01, init_error=1, no host writes, system_ready stays 0.
- H=1, S=17: one host write, then ERR with error_code=10.
- start_init re-pulsed mid-load is ignored. A second start after DONE clears system_ready, and the reload produces an identical write sequence.
- rst_n asserted in the middle of HOST_BODY: all outputs go to 0 immediately and the FSM is in IDLE. A subsequent start completes normally.
